// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename state (busy + ROB tag).
// Issue renames a destination, commit retires a value, flush drops all renames.
module rename_regfile #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int Q_WIDTH        = 5
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      issue_en,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [Q_WIDTH-1:0]        issue_Q,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [Q_WIDTH-1:0]        rs1_Q,
  output logic [Q_WIDTH-1:0]        rs2_Q,
  output logic [31:0]               rs1_V,
  output logic [31:0]               rs2_V,
  input  logic                      commit_en,
  input  logic [REG_ADDR_WIDTH-1:0] commit_rd,
  input  logic [Q_WIDTH-1:0]        commit_Q,
  input  logic [31:0]               commit_V,
  input  logic                      flush
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [31:0]        w_val  [NUM_REGS];
  logic               w_busy [NUM_REGS];
  logic [Q_WIDTH-1:0] w_tag  [NUM_REGS];

  // x0 is hardwired: never renamed, never written.
  assign w_val[0]  = '0;
  assign w_busy[0] = 1'b0;
  assign w_tag[0]  = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [31:0]        r_val;
      logic               r_busy;
      logic [Q_WIDTH-1:0] r_tag;
      logic               w_issue_hit;
      logic               w_commit_hit;
      logic               w_commit_owner;

      assign w_issue_hit    = issue_en && (issue_rd == REG_ADDR_WIDTH'(gi));
      assign w_commit_hit   = commit_en && (commit_rd == REG_ADDR_WIDTH'(gi));
      assign w_commit_owner = w_commit_hit && r_busy && (r_tag == commit_Q);

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_val  <= '0;
          r_busy <= 1'b0;
          r_tag  <= '0;
        end else if (rdy_in) begin
          if (w_commit_hit) begin
            r_val <= commit_V;
          end
          // Flush beats issue; a newer issue keeps the register busy over a commit.
          if (flush) begin
            r_busy <= 1'b0;
            r_tag  <= '0;
          end else if (w_issue_hit) begin
            r_busy <= 1'b1;
            r_tag  <= issue_Q;
          end else if (w_commit_owner) begin
            r_busy <= 1'b0;
          end
        end
      end

      assign w_val[gi]  = r_val;
      assign w_busy[gi] = r_busy;
      assign w_tag[gi]  = r_tag;
    end
  endgenerate

  logic [REG_ADDR_WIDTH-1:0] w_rd_addr [2];
  logic                      w_rd_busy [2];
  logic [Q_WIDTH-1:0]        w_rd_q    [2];
  logic [31:0]               w_rd_v    [2];

  assign w_rd_addr[0] = rs1_addr;
  assign w_rd_addr[1] = rs2_addr;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      // Committing owner is bypassed so issue sees the retired value this cycle.
      always_comb begin
        w_rd_busy[gi] = 1'b0;
        w_rd_q[gi]    = '0;
        w_rd_v[gi]    = '0;
        if (w_rd_addr[gi] != '0) begin
          if (commit_en && (commit_rd == w_rd_addr[gi]) && w_busy[w_rd_addr[gi]] &&
              (w_tag[w_rd_addr[gi]] == commit_Q)) begin
            w_rd_v[gi] = commit_V;
          end else if (w_busy[w_rd_addr[gi]]) begin
            w_rd_busy[gi] = 1'b1;
            w_rd_q[gi]    = w_tag[w_rd_addr[gi]];
          end else begin
            w_rd_v[gi] = w_val[w_rd_addr[gi]];
          end
        end
      end
    end
  endgenerate

  assign rs1_busy = w_rd_busy[0];
  assign rs1_Q    = w_rd_q[0];
  assign rs1_V    = w_rd_v[0];
  assign rs2_busy = w_rd_busy[1];
  assign rs2_Q    = w_rd_q[1];
  assign rs2_V    = w_rd_v[1];

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: stimulus pushes expected read results,
// a negedge monitor pops and compares them against the read ports.
module tb_rename_regfile;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  issue_Q = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rs1_Q, rs2_Q;
  logic [31:0] rs1_V, rs2_V;
  logic        commit_en = 1'b0;
  logic [4:0]  commit_rd = '0;
  logic [4:0]  commit_Q = '0;
  logic [31:0] commit_V = '0;
  logic        flush = 1'b0;

  rename_regfile #(.REG_ADDR_WIDTH(5), .Q_WIDTH(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_Q(issue_Q),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_Q(rs1_Q), .rs2_Q(rs2_Q), .rs1_V(rs1_V), .rs2_V(rs2_V),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_Q(commit_Q),
    .commit_V(commit_V), .flush(flush)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          port;
    logic        busy;
    logic [4:0]  q;
    logic [31:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_rd(input int port, input logic b, input logic [4:0] q,
                           input logic [31:0] v, input string name);
    exp_t e;
    e.port = port; e.busy = b; e.q = q; e.v = v; e.name = name;
    exp_q.push_back(e);
  endtask

  always @(negedge clk_in) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic        ab;
      logic [4:0]  aq;
      logic [31:0] av;
      e  = exp_q.pop_front();
      ab = (e.port == 1) ? rs1_busy : rs2_busy;
      aq = (e.port == 1) ? rs1_Q    : rs2_Q;
      av = (e.port == 1) ? rs1_V    : rs2_V;
      n_checks++;
      if (ab !== e.busy || aq !== e.q || av !== e.v) begin
        n_fail++;
        $display("FAIL %s rs%0d: got busy=%0b Q=%0d V=%h, expected busy=%0b Q=%0d V=%h",
                 e.name, e.port, ab, aq, av, e.busy, e.q, e.v);
      end else begin
        $display("ok   %s rs%0d: busy=%0b Q=%0d V=%h", e.name, e.port, ab, aq, av);
      end
    end
  end

  // Advance to just after the next rising edge and return strobes to idle.
  task automatic cyc();
    @(posedge clk_in);
    #1;
    issue_en  = 1'b0;
    commit_en = 1'b0;
    flush     = 1'b0;
    rdy_in    = 1'b1;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [4:0] q);
    issue_en = 1'b1; issue_rd = rd; issue_Q = q;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [4:0] q, input logic [31:0] v);
    commit_en = 1'b1; commit_rd = rd; commit_Q = q; commit_V = v;
  endtask

  task automatic rd2(input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1; rs2_addr = a2;
  endtask

  initial begin
    // Reset state
    cyc();
    rd2(5, 0);
    expect_rd(1, 0, 0, 0, "reset_x5");
    expect_rd(2, 0, 0, 0, "reset_x0");
    cyc();
    rst_in = 1'b1;
    rd2(5, 0);
    do_commit(0, 0, 32'hDEAD);
    expect_rd(1, 0, 0, 0, "post_reset_x5");
    expect_rd(2, 0, 0, 0, "x0_commit_same");
    cyc();
    rd2(0, 0);
    expect_rd(1, 0, 0, 0, "x0_after_commit");

    // Issue, read pending, commit with bypass
    cyc();
    do_issue(3, 7);
    rd2(3, 3);
    expect_rd(1, 0, 0, 0, "x3_issue_same_cycle");
    cyc();
    rd2(3, 3);
    expect_rd(1, 1, 7, 0, "x3_renamed");
    cyc();
    do_commit(3, 7, 32'h1234);
    rd2(3, 3);
    expect_rd(1, 0, 0, 32'h1234, "x3_bypass");
    expect_rd(2, 0, 0, 32'h1234, "x3_bypass");
    cyc();
    rd2(3, 3);
    expect_rd(2, 0, 0, 32'h1234, "x3_committed");

    // Stale commit does not clear a newer rename
    cyc();
    do_issue(4, 2);
    cyc();
    do_issue(4, 9);
    cyc();
    do_commit(4, 2, 32'h55);
    rd2(4, 4);
    expect_rd(1, 1, 9, 0, "x4_stale_commit_no_bypass");
    cyc();
    rd2(4, 4);
    expect_rd(2, 1, 9, 0, "x4_still_busy");
    cyc();
    do_commit(4, 9, 32'h66);
    rd2(4, 4);
    expect_rd(1, 0, 0, 32'h66, "x4_bypass_owner");
    cyc();
    rd2(4, 4);
    expect_rd(2, 0, 0, 32'h66, "x4_committed");

    // Same-cycle issue and commit to the same register
    cyc();
    do_issue(6, 5);
    cyc();
    do_issue(6, 11);
    do_commit(6, 5, 32'hABCD);
    rd2(6, 6);
    expect_rd(1, 0, 0, 32'hABCD, "x6_bypass_with_issue");
    cyc();
    rd2(6, 6);
    expect_rd(2, 1, 11, 0, "x6_reissued");

    // Rename every register, then flush with a simultaneous issue
    for (int i = 1; i < 32; i++) begin
      cyc();
      do_issue(5'(i), 5'(i));
    end
    cyc();
    rd2(2, 31);
    expect_rd(1, 1, 2, 0, "x2_renamed");
    expect_rd(2, 1, 31, 0, "x31_renamed");
    cyc();
    flush = 1'b1;
    do_issue(2, 3);
    rd2(2, 6);
    expect_rd(1, 1, 2, 0, "x2_during_flush");
    expect_rd(2, 1, 6, 0, "x6_during_flush");
    cyc();
    rd2(2, 6);
    expect_rd(1, 0, 0, 0, "x2_after_flush");
    expect_rd(2, 0, 0, 32'hABCD, "x6_after_flush");
    cyc();
    rd2(3, 4);
    expect_rd(1, 0, 0, 32'h1234, "x3_after_flush");
    expect_rd(2, 0, 0, 32'h66, "x4_after_flush");

    // rdy_in low freezes all state
    cyc();
    do_issue(10, 4);
    cyc();
    rd2(10, 10);
    expect_rd(1, 1, 4, 0, "x10_renamed");
    cyc();
    rdy_in = 1'b0;
    do_issue(3, 8);
    do_commit(3, 0, 32'h777);
    flush = 1'b1;
    rd2(3, 5);
    expect_rd(1, 0, 0, 32'h1234, "x3_during_stall");
    expect_rd(2, 0, 0, 0, "x5_during_stall");
    cyc();
    rd2(10, 3);
    expect_rd(1, 1, 4, 0, "x10_after_stall");
    expect_rd(2, 0, 0, 32'h1234, "x3_after_stall");

    // Asynchronous reset mid-cycle
    cyc();
    rd2(3, 10);
    #1;
    rst_in = 1'b0;
    expect_rd(1, 0, 0, 0, "x3_async_reset");
    expect_rd(2, 0, 0, 0, "x10_async_reset");
    cyc();
    rst_in = 1'b1;
    rd2(6, 10);
    expect_rd(1, 0, 0, 0, "x6_after_reset");
    expect_rd(2, 0, 0, 0, "x10_after_reset");

    cyc();
    @(negedge clk_in);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
